// File: rtl/adc_eth_pkg.sv
// adc_eth_pkg: shared states and constants for the ADC-to-Ethernet framer
package adc_eth_pkg;
    typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, FCS, IFG} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam int HDR_LEN = 14;
    localparam int PRE_LEN = 7;
endpackage

// File: rtl/adc_eth_framer_if.sv
// adc_eth_framer_if: sample RAM read port plus byte-wide transmit stream
interface adc_eth_framer_if #(parameter int ADDR_W = 11);
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic tx_en;
    logic tx_sof;
    logic tx_eof;
    modport master(output rd_addr, tx_data, tx_en, tx_sof, tx_eof, input rd_data);
    modport slave(input rd_addr, tx_data, tx_en, tx_sof, tx_eof, output rd_data);
endinterface

// File: rtl/adc_eth_framer_crc32_d8.sv
// crc32_d8: one-byte step of the reflected Ethernet CRC-32
module crc32_d8 import adc_eth_pkg::*; (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++)
            crc_out = (crc_out[0] ^ data[i]) ? (crc_out >> 1) ^ CRC_POLY_REFL : crc_out >> 1;
    end
endmodule

// File: rtl/adc_eth_framer.sv
// adc_eth_framer: sends each filled ADC half-buffer as one Ethernet II frame
module adc_eth_framer import adc_eth_pkg::*; #(
    parameter int ADDR_W = 11,
    parameter int PAYLOAD_LEN = 1024,
    parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int IFG_LEN = 12
) (
    input  logic clk125,
    input  logic rst_n,
    input  logic idx,
    adc_eth_framer_if.master bus,
    output logic busy,
    output logic [15:0] frames,
    output logic [15:0] drops
);
    localparam logic [111:0] HDR_BITS = {DST_MAC, SRC_MAC, ETHERTYPE};
    logic s1, s2, prev, half, trig, last;
    logic [2:0] arm;
    logic [15:0] cnt, len;
    logic [31:0] crc, crc_nxt;
    state_t state, nxt;
    // arm keeps the first synchronized level after reset from looking like a toggle
    assign trig = arm[2] & (s2 ^ prev);
    crc32_d8 u_crc (.crc_in(crc), .data(bus.tx_data), .crc_out(crc_nxt));
    always_comb begin
        len = state == PRE ? 16'(PRE_LEN) : state == SFD ? 16'd1 : state == HDR ? 16'(HDR_LEN) :
              state == PAY ? 16'(PAYLOAD_LEN) : state == FCS ? 16'd4 : 16'(IFG_LEN);
        last = cnt == len - 16'd1;
        nxt = state == IDLE ? (trig ? PRE : IDLE) : !last ? state :
              state == IFG ? IDLE : state_t'(state + 3'd1);
    end
    always_comb begin
        bus.tx_en = state inside {PRE, SFD, HDR, PAY, FCS};
        bus.tx_sof = state == PRE && cnt == 16'd0;
        bus.tx_eof = state == FCS && last;
        bus.tx_data = state == PRE ? PREAMBLE_BYTE : state == SFD ? SFD_BYTE :
                      state == HDR ? 8'(HDR_BITS >> {4'(HDR_LEN - 1) - cnt[3:0], 3'b000}) :
                      state == PAY ? bus.rd_data :
                      state == FCS ? 8'(~crc >> {cnt[1:0], 3'b000}) : 8'h00;
        busy = state != IDLE;
    end
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            prev <= 1'b0;
            arm <= 3'b000;
            state <= IDLE;
            cnt <= 16'd0;
            half <= 1'b0;
            crc <= CRC_INIT;
            bus.rd_addr <= '0;
            frames <= 16'd0;
            drops <= 16'd0;
        end else begin
            s1 <= idx;
            s2 <= s1;
            prev <= s2;
            arm <= {arm[1:0], 1'b1};
            state <= nxt;
            cnt <= (state == IDLE || last) ? 16'd0 : cnt + 16'd1;
            if (state == IDLE && trig) begin
                half <= ~s2;
                crc <= CRC_INIT;
            end
            if (state == HDR || state == PAY)
                crc <= crc_nxt;
            // RAM has two cycles of read latency: start addressing at HDR byte 12
            if (state == HDR && cnt == 16'(HDR_LEN - 3))
                bus.rd_addr <= {half, {(ADDR_W-1){1'b0}}};
            else if ((state == HDR && cnt >= 16'(HDR_LEN - 2)) ||
                     (state == PAY && cnt + 16'd3 < 16'(PAYLOAD_LEN)))
                bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
            if (bus.tx_eof)
                frames <= frames + 16'd1;
            if (trig && busy && drops != 16'hFFFF)
                drops <= drops + 16'd1;
        end
    end
endmodule
